// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
//   parity_e  : parity mode (none / even / odd)
//   state_e   : receiver FSM states
//   calc_mod  : clocks per bit, rounded to nearest
package uart_pkg;

    typedef enum logic [1:0] {
        ParNone = 2'd0,
        ParEven = 2'd1,
        ParOdd  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    function automatic int unsigned calc_mod(input int unsigned f, input int unsigned baud);
        return (f + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_counter.sv
// Bit-period counter: counts 0..N-1 and wraps.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset (count -> 0)
//   clr     : synchronous clear (count -> 0)
//   count   : current count value
module uart_counter #(
    parameter int unsigned N = 10,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] Last = W'(N - 1);

    always_ff @(posedge i_clk) begin
        if (i_rst || clr) begin
            count <= '0;
        end else if (count == Last) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_gen.sv
// UART receiver with 3-sample majority vote, optional parity, 1 or 2 stop bits.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_rx          : asynchronous serial line, idle high
//   o_data        : received word, LSB first on the line
//   o_valid       : word/flags valid, held until i_ready
//   i_ready       : consumer accepts when o_valid & i_ready
//   o_parity_err  : parity mismatch for o_data
//   o_frame_err   : a stop bit sampled low for o_data
//   o_overrun     : one-cycle pulse when a completed frame is dropped
//   o_busy        : FSM not idle
module uart_rx_gen
    import uart_pkg::*;
#(
    parameter int unsigned F           = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int unsigned   MOD      = calc_mod(F, BAUD);
    localparam int unsigned   CW       = $clog2(MOD);
    localparam logic [CW-1:0] SampA    = CW'(MOD / 2 - 1);
    localparam logic [CW-1:0] SampB    = CW'(MOD / 2);
    localparam logic [CW-1:0] SampC    = CW'(MOD / 2 + 1);
    localparam parity_e       ParMode  = parity_e'(PARITY[1:0]);
    localparam logic [3:0]    LastBit  = 4'(DATA_BITS - 1);
    localparam logic [1:0]    LastStop = 2'(STOP_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    state_e                 state_q, state_d;
    logic [CW-1:0]          count;
    logic                   cnt_clr;
    logic [1:0]             samp_q;
    logic                   maj;
    logic                   decide;
    logic                   deliver;
    logic [3:0]             bit_cnt_q;
    logic [1:0]             stop_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_err_q;
    logic                   frm_err_q;
    logic                   exp_par;

    // Synchroniser resets to the idle (high) line level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Held at zero while idle so the first START cycle sees count 0.
    assign cnt_clr = (state_q == StIdle) || (state_q == StBreak);

    uart_counter #(
        .N (MOD)
    ) u_counter (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .clr   (cnt_clr),
        .count (count)
    );

    // Third sample is the live synchronised line at the decision cycle.
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign decide  = (count == SampC) && (state_q != StIdle) && (state_q != StBreak);
    assign exp_par = (ParMode == ParOdd) ? ~(^shift_q) : (^shift_q);
    assign o_busy  = (state_q != StIdle);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        deliver = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (decide) state_d = maj ? StIdle : StData;
            end
            StData: begin
                if (decide && (bit_cnt_q == LastBit)) begin
                    state_d = (ParMode != ParNone) ? StParity : StStop;
                end
            end
            StParity: begin
                if (decide) state_d = StStop;
            end
            StStop: begin
                if (decide && (stop_cnt_q == LastStop)) begin
                    deliver = 1'b1;
                    state_d = maj ? StIdle : StBreak;
                end
            end
            StBreak: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            samp_q       <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;

            // Frame start: clear per-frame bookkeeping.
            if ((state_q == StIdle) && !rx_s) begin
                bit_cnt_q  <= '0;
                stop_cnt_q <= '0;
                par_err_q  <= 1'b0;
                frm_err_q  <= 1'b0;
            end

            if (count == SampA) samp_q[0] <= rx_s;
            if (count == SampB) samp_q[1] <= rx_s;

            if (decide) begin
                case (state_q)
                    StData: begin
                        shift_q   <= {maj, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                    StParity: par_err_q <= maj ^ exp_par;
                    StStop: begin
                        frm_err_q  <= frm_err_q | ~maj;
                        stop_cnt_q <= stop_cnt_q + 2'd1;
                    end
                    default: ;
                endcase
            end

            if (deliver && (!o_valid || i_ready)) begin
                o_data       <= shift_q;
                o_parity_err <= par_err_q;
                o_frame_err  <= frm_err_q | ~maj;
                o_valid      <= 1'b1;
            end else if (deliver) begin
                o_overrun <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_gen.md
UART_RX_GEN -- requirements
Module: uart_rx_gen

Interface
REQ-001 Parameter F, 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 115200, line rate in bit/s; MOD = (F+BAUD/2)/BAUD clocks per bit, MOD >= 8.
REQ-003 Parameter DATA_BITS, 8, data bits per frame, legal 5..9.
REQ-004 Parameter PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, 1, stop bits checked, legal 1 or 2.
REQ-006 Parameter SYNC_STAGES, 2, input synchroniser depth, legal >= 2.
REQ-007 i_clk  in  1  system clock, all logic on rising edge.
REQ-008 i_rst  in  1  reset, synchronous, active-high.
REQ-009 i_rx  in  1  asynchronous serial line, idle high.
REQ-010 o_data  out  DATA_BITS  received word, LSB = first bit on line.
REQ-011 o_valid  out  1  o_data and error flags valid; held until accepted.
REQ-012 i_ready  in  1  consumer accepts word when o_valid & i_ready.
REQ-013 o_parity_err  out  1  parity mismatch for the word in o_data; qualified by o_valid.
REQ-014 o_frame_err  out  1  a stop bit sampled low for the word in o_data; qualified by o_valid.
REQ-015 o_overrun  out  1  one-cycle pulse when a completed frame is discarded.
REQ-016 o_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 i_rx SHALL pass through SYNC_STAGES flops; all decisions use the synchronised line rx_s.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-019 IDLE -> START on rx_s = 0; the bit-period counter SHALL clear on entry to START and count 0..MOD-1, then wrap.
REQ-020 Each bit SHALL be sampled at counter values MOD/2-1, MOD/2 and MOD/2+1; bit value = 2-of-3 majority, decided at MOD/2+1.
REQ-021 START: majority 1 -> IDLE (glitch rejected, no output, no flags); majority 0 -> DATA.
REQ-022 DATA SHALL shift in exactly DATA_BITS bits LSB first, then go to PARITY if PARITY != 0, else to STOP.
REQ-023 PARITY: the sampled bit SHALL be compared with XOR of data bits (even) or its inverse (odd); a mismatch sets the frame parity error.
REQ-024 STOP SHALL sample STOP_BITS bits; any stop majority 0 sets the frame error.
REQ-025 After the last stop decision: stop bit 1 -> IDLE in the next cycle; stop bit 0 -> BREAK, which holds until rx_s = 1, then -> IDLE.
REQ-026 On the last stop decision with o_valid low, or with o_valid & i_ready high in that cycle, o_data/o_parity_err/o_frame_err SHALL load and o_valid SHALL rise on the next clock edge (latency: 1 cycle after the MOD/2+1 sample of the last stop bit).
REQ-027 If o_valid is high and i_ready is low at that decision, the new frame SHALL be discarded, held data SHALL remain unchanged, and o_overrun SHALL pulse for one cycle.
REQ-028 o_valid SHALL fall the cycle after o_valid & i_ready, unless REQ-026 reloads it in the same cycle.
REQ-029 o_parity_err SHALL be 0 when PARITY = 0; flags SHALL be delivered with their word, not sticky.
REQ-030 o_busy SHALL be high in START, DATA, PARITY, STOP and BREAK.

Reset
REQ-031 i_rst SHALL force the synchroniser flops to 1, the FSM to IDLE, the counters to 0, and o_valid, o_parity_err, o_frame_err, o_overrun and o_busy to 0; o_data SHALL reset to 0.
REQ-032 An i_rst asserted mid-frame SHALL abandon the frame without output; reception SHALL restart only on a new falling edge after release.

Structure
REQ-033 Package uart_pkg SHALL hold the parity-mode enum, the FSM state enum and the MOD constant function.
REQ-034 Bit-period timing SHALL use one uart_counter instance (N = MOD); bit indexing SHALL be local.

Verification (F = 1152000, BAUD = 115200, MOD = 10)
REQ-035 8N1, byte 0xA5, i_ready = 1 -> o_data = 0xA5, one-cycle o_valid, both error flags 0.
REQ-036 8E1, byte 0x03 sent with parity bit 1 -> o_data = 0x03, o_parity_err = 1; 8O1 with the same bits -> o_parity_err = 0.
REQ-037 Low pulse of 3 clocks on an idle line -> no o_valid, o_busy returns to 0 within MOD cycles.
REQ-038 8N2, 0x55 with second stop bit low, line then held low for 30 clocks -> o_frame_err = 1; FSM stays in BREAK until the line is high; next frame 0x12 is received correctly.
REQ-039 i_ready = 0, frames 0x11 then 0x22 -> o_data stays 0x11, o_overrun pulses once; raising i_ready clears o_valid.
REQ-040 9N1 frame 0x1FF with a one-clock glitch at each mid-bit sample -> majority vote yields 0x1FF; i_rst mid-frame -> no output.
